thumb_fetch: RTL and testbench

THUMB_FETCH -- requirements
Module: thumb_fetch

---
 rtl/thumb_fetch_if.sv | 26 ++
 rtl/thumb_fetch.sv | 129 ++++++++++++
 tb/tb_thumb_fetch.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/thumb_fetch_if.sv
// Thumb fetch unit signal bundle: instruction-memory read port on one side,
// decode-facing instruction stream and redirect/stall controls on the other.
// The master view belongs to the fetch unit; the slave view to its environment.
interface thumb_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [15:0] instr;
  logic [5:0]  preOpcode;
  logic [31:0] instr_pc;
  logic        instr_valid;

  modport master (
    output imem_req, imem_addr, instr, preOpcode, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr, preOpcode, instr_pc, instr_valid,
    output imem_ack, imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/thumb_fetch.sv
// Thumb instruction fetch: one outstanding halfword read, a 2-entry prefetch
// FIFO of {halfword, pc} feeding decode, and redirect handling that discards
// any read already in flight (FLUSH) before fetching from the new target.
module thumb_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  thumb_fetch_if.master bus
);

  typedef enum logic [1:0] {FETCH, WAIT, FLUSH} state_e;

  typedef struct packed {
    logic [15:0] hw;
    logic [31:0] pc;
  } entry_t;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFE;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, req_addr_d;   // address held while WAIT/FLUSH
  logic [1:0]  count_q, count_d;
  entry_t      fifo_q [2];
  entry_t      fifo_d [2];

  logic        pop;
  logic        push;
  logic        req;
  logic [31:0] addr;
  logic [1:0]  count_after_pop;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = bus.redirect_pc & 32'hFFFF_FFFE;

  // The head entry is always on the decode outputs; a redirect this cycle
  // hides it because the edge will flush it.
  assign bus.instr       = fifo_q[0].hw;
  assign bus.preOpcode   = fifo_q[0].hw[15:10];
  assign bus.instr_pc    = fifo_q[0].pc;
  assign bus.instr_valid = (count_q != 2'd0) && !bus.redirect;

  assign pop             = bus.instr_valid && !bus.stall;
  assign count_after_pop = count_q - {1'b0, pop};

  // The FSM output would otherwise request during reset; the request is
  // abandoned for as long as rst is held.
  assign bus.imem_req  = req && !rst;
  assign bus.imem_addr = addr;

  // Fetch FSM: request issue, wait for ack, discard of stale data, PC update.
  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    req        = 1'b0;
    push       = 1'b0;
    addr       = fetch_pc_q;

    case (state_q)
      FETCH: begin
        req  = (count_after_pop < 2'd2);
        addr = fetch_pc_q;
        if (req && !bus.imem_ack) begin
          req_addr_d = fetch_pc_q;
          state_d    = bus.redirect ? FLUSH : WAIT;
        end else if (req && bus.imem_ack) begin
          push = !bus.redirect;
        end
      end
      WAIT: begin
        req  = 1'b1;
        addr = req_addr_q;
        if (bus.imem_ack) begin
          push    = !bus.redirect;
          state_d = FETCH;
        end else if (bus.redirect) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        req  = 1'b1;
        addr = req_addr_q;
        if (bus.imem_ack) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (bus.redirect)  fetch_pc_d = redirect_tgt;
    else if (push)     fetch_pc_d = fetch_pc_q + 32'd2;
  end

  // Prefetch FIFO: shift on pop, write behind the surviving entries on push.
  always_comb begin
    fifo_d  = fifo_q;
    count_d = count_after_pop;
    if (pop) fifo_d[0] = fifo_q[1];
    if (push) begin
      fifo_d[count_after_pop[0]] = entry_t'{hw: bus.imem_rdata, pc: fetch_pc_q};
      count_d                    = count_after_pop + 2'd1;
    end
    if (bus.redirect) count_d = 2'd0;
  end

  // State registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC_ALIGNED;
      req_addr_q <= '0;
      count_q    <= '0;
      // NOTE: the FIFO storage is reset too, because instr/instr_pc must read
      // zero during reset; a larger buffer would normally be left unreset.
      fifo_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      count_q    <= count_d;
      fifo_q     <= fifo_d;
    end
  end

endmodule

// File: tb/tb_thumb_fetch.sv
// Bench for thumb_fetch: directed steps for reset, streaming, stall/fill,
// redirect-in-wait, redirect-with-ack, PC wrap and mid-wait reset, then a
// randomized run against an in-order instruction-stream reference model.
module tb_thumb_fetch;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model / memory responder state
  logic [31:0] exp_pc;
  logic        busy;
  logic [31:0] busy_addr;
  int          lat;
  int          idle;
  logic        st;
  logic        rd;
  logic [31:0] rpc;
  logic [15:0] w;

  always #5 clk = ~clk;

  thumb_fetch_if bus ();

  thumb_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory image: every halfword address holds a distinct pattern.
  function automatic logic [15:0] mem_word(input logic [31:0] a);
    return a[16:1] ^ a[31:16] ^ 16'hC35A;
  endfunction

  // Drive decode-side inputs for this cycle with no ack, then let outputs settle.
  task automatic drive(input logic s, input logic r, input logic [31:0] p);
    bus.stall       = s;
    bus.redirect    = r;
    bus.redirect_pc = p;
    bus.imem_ack    = 1'b0;
    #1;
  endtask

  task automatic respond(input logic a, input logic [15:0] d);
    bus.imem_ack   = a;
    bus.imem_rdata = d;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [15:0] hw);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    check({tag, "_pc"},    bus.instr_pc, pc);
    check({tag, "_instr"}, 32'(bus.instr), 32'(hw));
    check({tag, "_preop"}, 32'(bus.preOpcode), 32'(hw[15:10]));
  endtask

  initial begin
    rst             = 1'b1;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = '0;

    // Reset state with the clock running
    repeat (3) @(posedge clk);
    #1;
    check("rst_req",   32'(bus.imem_req), 32'd0);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", 32'(bus.instr), 32'd0);
    check("rst_preop", 32'(bus.preOpcode), 32'd0);
    check("rst_pc",    bus.instr_pc, 32'd0);
    rst = 1'b0;

    // Zero-wait streaming from RESET_PC
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 32'd0);
      check("zw_req",   32'(bus.imem_req), 32'd1);
      check("zw_addr",  bus.imem_addr, 32'(2 * i));
      check("zw_valid", 32'(bus.instr_valid), 32'(i != 0));
      if (i != 0) check_head("zw", 32'(2 * (i - 1)), mem_word(32'(2 * (i - 1))));
      respond(1'b1, mem_word(32'(2 * i)));
      next_cycle();
    end

    // Redirect together with ack: data dropped, next request at target
    drive(1'b0, 1'b1, 32'h0000_0200);
    check("rda_valid", 32'(bus.instr_valid), 32'd0);
    check("rda_addr",  bus.imem_addr, 32'd12);
    respond(1'b1, 16'hDEAD);
    next_cycle();

    // Stall for 5 cycles while memory returns E7FE then 4770
    drive(1'b1, 1'b0, 32'd0);
    check("rda_next_addr",  bus.imem_addr, 32'h0000_0200);
    check("rda_next_req",   32'(bus.imem_req), 32'd1);
    check("rda_next_valid", 32'(bus.instr_valid), 32'd0);
    respond(1'b1, 16'hE7FE);
    next_cycle();

    drive(1'b1, 1'b0, 32'd0);
    check("st_addr1", bus.imem_addr, 32'h0000_0202);
    check_head("st_b", 32'h0000_0200, 16'hE7FE);
    respond(1'b1, 16'h4770);
    next_cycle();

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'd0);
      check("st_full_req", 32'(bus.imem_req), 32'd0);
      check_head("st_full", 32'h0000_0200, 16'hE7FE);
      check("st_preop_lit", 32'(bus.preOpcode), 32'(6'b111001));
      respond(1'b1, 16'hBAD0);   // stray ack while idle
      next_cycle();
    end

    // Stall released: E7FE popped, 4770 next, request goes out and waits
    drive(1'b0, 1'b0, 32'd0);
    check_head("rel_a", 32'h0000_0200, 16'hE7FE);
    check("rel_req",  32'(bus.imem_req), 32'd1);
    check("rel_addr", bus.imem_addr, 32'h0000_0204);
    respond(1'b0, 16'h0);
    next_cycle();

    drive(1'b0, 1'b0, 32'd0);
    check_head("rel_b", 32'h0000_0202, 16'h4770);
    check("wait_addr", bus.imem_addr, 32'h0000_0204);
    respond(1'b0, 16'h0);
    next_cycle();

    // Redirect while waiting; ack arrives 3 cycles later and is discarded
    drive(1'b0, 1'b1, 32'h0000_0101);
    check("rdw_valid", 32'(bus.instr_valid), 32'd0);
    check("rdw_addr",  bus.imem_addr, 32'h0000_0204);
    respond(1'b0, 16'h0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'd0);
      check("fl_req",   32'(bus.imem_req), 32'd1);
      check("fl_addr",  bus.imem_addr, 32'h0000_0204);
      check("fl_valid", 32'(bus.instr_valid), 32'd0);
      respond(i == 2, 16'h1234);
      next_cycle();
    end
    drive(1'b0, 1'b0, 32'd0);
    check("fl_new_addr",  bus.imem_addr, 32'h0000_0100);
    check("fl_new_valid", 32'(bus.instr_valid), 32'd0);
    respond(1'b0, 16'h0);
    next_cycle();
    drive(1'b0, 1'b0, 32'd0);
    check("fl_new_addr2",  bus.imem_addr, 32'h0000_0100);
    check("fl_new_valid2", 32'(bus.instr_valid), 32'd0);
    respond(1'b1, mem_word(32'h0000_0100));
    next_cycle();
    drive(1'b0, 1'b0, 32'd0);
    check_head("fl_ret", 32'h0000_0100, mem_word(32'h0000_0100));
    respond(1'b1, mem_word(32'h0000_0102));
    next_cycle();

    // Redirect to the top of the address space (bit0 forced low), then wrap
    drive(1'b0, 1'b1, 32'hFFFF_FFFF);
    check("wr_rd_valid", 32'(bus.instr_valid), 32'd0);
    respond(1'b1, 16'h5555);
    next_cycle();
    drive(1'b0, 1'b0, 32'd0);
    check("wr_addr", bus.imem_addr, 32'hFFFF_FFFE);
    respond(1'b1, mem_word(32'hFFFF_FFFE));
    next_cycle();
    drive(1'b0, 1'b0, 32'd0);
    check_head("wr", 32'hFFFF_FFFE, mem_word(32'hFFFF_FFFE));
    check("wr_next_addr", bus.imem_addr, 32'h0000_0000);
    respond(1'b1, mem_word(32'h0000_0000));
    next_cycle();

    // Stall with count=1 and leave a request waiting at address 2
    drive(1'b1, 1'b0, 32'd0);
    check("rw_addr", bus.imem_addr, 32'h0000_0002);
    respond(1'b0, 16'h0);
    next_cycle();
    drive(1'b1, 1'b0, 32'd0);
    check_head("rw", 32'h0000_0000, mem_word(32'h0000_0000));
    check("rw_req", 32'(bus.imem_req), 32'd1);
    respond(1'b0, 16'h0);
    #2;
    rst = 1'b1;                 // asynchronous, mid-cycle
    #1;
    check("ar_req",   32'(bus.imem_req), 32'd0);
    check("ar_valid", 32'(bus.instr_valid), 32'd0);
    check("ar_pc",    bus.instr_pc, 32'd0);
    next_cycle();
    check("ar_hold_req", 32'(bus.imem_req), 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'd0);
    check("ar_first_req",  32'(bus.imem_req), 32'd1);
    check("ar_first_addr", bus.imem_addr, 32'h0000_0000);
    next_cycle();               // no ack: request is now outstanding

    // Randomized run against the in-order stream model
    exp_pc    = 32'h0000_0000;
    busy      = 1'b1;
    busy_addr = 32'h0000_0000;
    lat       = 1;
    idle      = 0;
    for (int c = 0; c < 3000; c++) begin
      st = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 99) < 4);
      case ($urandom_range(0, 3))
        0:       rpc = $urandom;
        1:       rpc = 32'hFFFF_FFF8 | ($urandom & 32'h7);
        default: rpc = $urandom & 32'h0000_0FFF;
      endcase
      drive(st, rd, rpc);

      if (bus.imem_req) begin
        if (!busy) begin
          busy      = 1'b1;
          busy_addr = bus.imem_addr;
          lat       = $urandom_range(0, 3);
        end else begin
          check("r_addr_hold", bus.imem_addr, busy_addr);
        end
        check("r_addr_align", 32'(bus.imem_addr[0]), 32'd0);
        if (lat == 0) begin
          respond(1'b1, mem_word(busy_addr));
          busy = 1'b0;
        end else begin
          lat--;
          respond(1'b0, 16'($urandom));
        end
      end else begin
        if (busy) check("r_req_hold", 32'(bus.imem_req), 32'd1);
        respond($urandom_range(0, 9) == 0, 16'($urandom));
      end

      if (rd) begin
        check("r_rd_valid", 32'(bus.instr_valid), 32'd0);
      end else if (bus.instr_valid) begin
        w = mem_word(exp_pc);
        check_head("r", exp_pc, w);
      end

      if (bus.instr_valid || rd) idle = 0;
      else                       idle++;
      check("r_starve", 32'(idle > 12), 32'd0);

      if (rd)                          exp_pc = rpc & 32'hFFFF_FFFE;
      else if (bus.instr_valid && !st) exp_pc = exp_pc + 32'd2;
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
